// File: rtl/uart_tx_queue_pkg.sv
// uart_tx_queue_pkg
// Shared definitions for the UART transmit queue:
//   UART_TXQ_DEPTH      default queue capacity in bytes
//   UART_TXQ_CW         level counter width for the default depth
//   uart_txq_status_t   status word returned through the MMIO read mux
//   UART_TXQ_*_OFS      MMIO offsets of the TX data, status and flush registers
package uart_tx_queue_pkg;

  localparam int unsigned UART_TXQ_DEPTH = 16;
  localparam int unsigned UART_TXQ_CW    = $clog2(UART_TXQ_DEPTH) + 1;

  localparam logic [7:0] UART_TXQ_DATA_OFS   = 8'h00;
  localparam logic [7:0] UART_TXQ_STATUS_OFS = 8'h04;
  localparam logic [7:0] UART_TXQ_FLUSH_OFS  = 8'h08;

  // Embedded in the UART section of the MMIO register block.
  typedef struct packed {
    logic                   overflow;
    logic                   full;
    logic                   empty;
    logic [UART_TXQ_CW-1:0] level;
  } uart_txq_status_t;

endpackage

// File: rtl/uart_tx_queue.sv
// uart_tx_queue
// Byte queue between the MMIO store path and the uart_tx serializer.
// Ports:
//   clk, rst_n          system clock, synchronous active-low reset
//   wr_en, wr_data      single-cycle push of one byte
//   flush               synchronous clear of contents and overflow flag
//   tx_valid, tx_data   head byte offered to uart_tx
//   tx_ready            uart_tx accepts the head byte
//   level, empty, full  fill status
//   overflow            sticky: a push was dropped while full
module uart_tx_queue
  import uart_tx_queue_pkg::*;
#(
  parameter int unsigned DEPTH = UART_TXQ_DEPTH,
  parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          flush,
  output logic          tx_valid,
  output logic [7:0]    tx_data,
  input  logic          tx_ready,
  output logic [CW-1:0] level,
  output logic          empty,
  output logic          full,
  output logic          overflow
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [CW-1:0] level_q, level_d;
  logic          overflow_q, overflow_d;

  logic push;
  logic pop;

  assign empty    = (level_q == '0);
  assign full     = (level_q == CW'(DEPTH));
  assign level    = level_q;
  assign overflow = overflow_q;
  assign tx_valid = !empty;
  // Read of registered state only, so tx_ready never reaches tx_data.
  assign tx_data  = empty ? 8'h00 : mem_q[rp_q];

  // full/empty are pre-edge values: a push into a full queue is dropped even
  // when a pop frees a slot at the same edge, and a push into an empty queue
  // cannot be popped at the edge that writes it.
  assign push = wr_en && !full && !flush;
  assign pop  = tx_valid && tx_ready && !flush;

  always_comb begin
    mem_d      = mem_q;
    wp_d       = wp_q;
    rp_d       = rp_q;
    level_d    = level_q;
    overflow_d = overflow_q;

    if (flush) begin
      wp_d       = '0;
      rp_d       = '0;
      level_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (push) begin
        mem_d[wp_q] = wr_data;
        wp_d        = wp_q + AW'(1);
      end
      if (pop) begin
        rp_d = rp_q + AW'(1);
      end
      if (wr_en && full) begin
        overflow_d = 1'b1;
      end
      case ({push, pop})
        2'b10:   level_d = level_q + CW'(1);
        2'b01:   level_d = level_q - CW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp_q       <= '0;
      rp_q       <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is not reset; level gates every read of it.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_uart_tx_queue.sv
module tb_uart_tx_queue;

  localparam int DEPTH = 16;
  localparam int CW    = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          flush = 1'b0;
  logic          tx_valid;
  logic [7:0]    tx_data;
  logic          tx_ready = 1'b0;
  logic [CW-1:0] level;
  logic          empty;
  logic          full;
  logic          overflow;

  int total = 0;
  int bad   = 0;
  bit check_en = 1'b0;

  logic [7:0] q[$];
  logic [7:0] popped[$];
  bit         ovf_m = 1'b0;

  uart_tx_queue #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .flush    (flush),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .level    (level),
    .empty    (empty),
    .full     (full),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of bytes, updated from the inputs seen at each edge.
  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      ovf_m = 1'b0;
    end else if (flush) begin
      q.delete();
      ovf_m = 1'b0;
    end else begin
      automatic bit was_full  = (q.size() == DEPTH);
      automatic bit was_empty = (q.size() == 0);
      if (wr_en && was_full) ovf_m = 1'b1;
      if (!was_empty && tx_ready) popped.push_back(q.pop_front());
      if (wr_en && !was_full) q.push_back(wr_data);
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      check("tx_valid", {31'b0, tx_valid}, {31'b0, q.size() != 0});
      check("tx_data",  {24'b0, tx_data},  {24'b0, (q.size() != 0) ? q[0] : 8'h00});
      check("level",    {27'b0, level},    q.size());
      check("empty",    {31'b0, empty},    {31'b0, q.size() == 0});
      check("full",     {31'b0, full},     {31'b0, q.size() == DEPTH});
      check("overflow", {31'b0, overflow}, {31'b0, ovf_m});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_n(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      wr_en   = 1'b1;
      wr_data = base + 8'(i);
      step();
    end
    wr_en = 1'b0;
  endtask

  initial begin
    int n0;

    // Reset values
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check_en = 1'b1;
    check("rst tx_valid", {31'b0, tx_valid}, 0);
    check("rst tx_data", {24'b0, tx_data}, 0);
    check("rst empty", {31'b0, empty}, 1);
    check("rst full", {31'b0, full}, 0);
    check("rst overflow", {31'b0, overflow}, 0);

    // Three pushes with serializer busy, then drain
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1;
      wr_data = 8'h41 + 8'(i);
      step();
      check("lvl after push", {27'b0, level}, i + 1);
    end
    wr_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("head held", {23'b0, tx_valid, tx_data}, 32'h141);
    end
    tx_ready = 1'b1;
    repeat (3) step();
    tx_ready = 1'b0;
    check("drain empty", {31'b0, empty}, 1);
    check("drain data0", {24'b0, tx_data}, 0);
    check("drain count", popped.size(), 3);
    for (int i = 0; i < 3 && i < popped.size(); i++)
      check("drain order", {24'b0, popped[i]}, 32'h41 + i);
    popped.delete();

    // Fill to full plus one
    push_n(16, 8'h00);
    check("full at 16", {31'b0, full}, 1);
    check("no ovf yet", {31'b0, overflow}, 0);
    push_n(1, 8'h10);
    check("ovf set", {31'b0, overflow}, 1);
    check("lvl 16", {27'b0, level}, 16);

    // Push and pop together while full: pop wins, push dropped
    wr_en = 1'b1;
    wr_data = 8'hAA;
    tx_ready = 1'b1;
    step();
    wr_en = 1'b0;
    check("full pp lvl", {27'b0, level}, 15);
    check("full pp ovf", {31'b0, overflow}, 1);
    repeat (15) step();
    tx_ready = 1'b0;
    check("full drain count", popped.size(), 16);
    for (int i = 0; i < 16 && i < popped.size(); i++)
      check("full drain order", {24'b0, popped[i]}, i);
    popped.delete();

    // Half-full streaming across pointer wraps
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush ovf clr", {31'b0, overflow}, 0);
    push_n(8, 8'h80);
    tx_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      wr_en = 1'b1;
      wr_data = 8'h88 + 8'(i);
      step();
      check("stream lvl", {27'b0, level}, 8);
    end
    wr_en = 1'b0;
    tx_ready = 1'b0;
    check("stream count", popped.size(), 40);
    for (int i = 0; i < 40 && i < popped.size(); i++)
      check("stream order", {24'b0, popped[i]}, 32'h80 + i);

    // Flush colliding with push and handshake at level 5 with overflow set
    flush = 1'b1;
    step();
    flush = 1'b0;
    push_n(17, 8'h20);
    tx_ready = 1'b1;
    repeat (11) step();
    tx_ready = 1'b0;
    check("pre flush lvl", {27'b0, level}, 5);
    check("pre flush ovf", {31'b0, overflow}, 1);
    flush = 1'b1;
    wr_en = 1'b1;
    wr_data = 8'hEE;
    tx_ready = 1'b1;
    step();
    flush = 1'b0;
    wr_en = 1'b0;
    check("flush lvl", {27'b0, level}, 0);
    check("flush valid", {31'b0, tx_valid}, 0);
    check("flush ovf", {31'b0, overflow}, 0);
    n0 = popped.size();
    repeat (5) step();
    check("no bytes after flush", popped.size(), n0);
    tx_ready = 1'b0;

    // Reset mid-drain
    push_n(10, 8'h60);
    tx_ready = 1'b1;
    repeat (3) step();
    check("pre rst lvl", {27'b0, level}, 7);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    tx_ready = 1'b0;
    check("rst2 valid", {31'b0, tx_valid}, 0);
    check("rst2 data", {24'b0, tx_data}, 0);
    check("rst2 lvl", {27'b0, level}, 0);
    check("rst2 empty", {31'b0, empty}, 1);
    push_n(1, 8'h55);
    check("post rst push", {23'b0, tx_valid, tx_data}, 32'h155);
    step();

    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
